// File: rtl/gptp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gptp_pkg
// Purpose : Shared definitions for the multi-port gPTP receive path:
//           messageType codes, parsed-frame field offsets, the stored entry
//           layout and the messageType -> buffer index map.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gptp_pkg;

  // gPTP messageType codes
  localparam logic [3:0] c_MT_SYNC         = 4'h0;
  localparam logic [3:0] c_MT_PDELAY_REQ   = 4'h2;
  localparam logic [3:0] c_MT_PDELAY_RESP  = 4'h3;
  localparam logic [3:0] c_MT_FOLLOW_UP    = 4'h8;
  localparam logic [3:0] c_MT_PDELAY_RFU   = 4'hA;
  localparam logic [3:0] c_MT_ANNOUNCE     = 4'hB;
  localparam logic [3:0] c_MT_SIGNALING    = 4'hC;

  // Number of stored message types (buffer index 7 is never used)
  localparam int c_N_TYPE = 7;

  // Parsed-frame field layout
  localparam int c_TS_W        = 80;
  localparam int c_RX_TS_LSB   = 352;
  localparam int c_MT_LSB      = 348;
  localparam int c_SEQ_LSB     = 332;
  localparam int c_MSG_TS_LSB  = 252;

  typedef struct packed {
    logic [15:0]         seq;
    logic [c_TS_W-1:0]   rx_ts;
    logic [c_TS_W-1:0]   msg_ts;
  } entry_t;

  // Returns {supported, index[2:0]}
  function automatic logic [3:0] type_map(input logic [3:0] i_mt);
    logic [3:0] w_res;
    case (i_mt)
      c_MT_SYNC:        w_res = 4'b1_000;
      c_MT_PDELAY_REQ:  w_res = 4'b1_001;
      c_MT_PDELAY_RESP: w_res = 4'b1_010;
      c_MT_FOLLOW_UP:   w_res = 4'b1_011;
      c_MT_PDELAY_RFU:  w_res = 4'b1_100;
      c_MT_ANNOUNCE:    w_res = 4'b1_101;
      c_MT_SIGNALING:   w_res = 4'b1_110;
      default:          w_res = 4'b0_000;
    endcase
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gptp_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gptp_rx_fifo
// Purpose : DEPTH-entry show-ahead FIFO for one (port, type) buffer.
//           Optional overwrite-oldest behaviour when full.
// Ports   : clk, reset (async active-low)
//           i_push/i_data : write request and entry
//           i_pop         : pop head (ignored when empty)
//           o_head        : head entry, zero when empty
//           o_empty       : buffer empty
//           o_ovf         : push hit a full buffer with no same-cycle pop
// Revision: 1.0 - initial release
// ============================================================================
module gptp_rx_fifo #(
  parameter int DEPTH    = 4,
  parameter int W        = 176,
  parameter bit OVR_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_ovf
);

  localparam int c_AW = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr;
  logic [c_AW-1:0] r_rd;
  logic [c_AW:0]   r_cnt;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop_old;

  always_comb begin
    o_empty    = (r_cnt == '0);
    w_full     = (r_cnt == (c_AW+1)'(DEPTH));
    w_pop      = i_pop & ~o_empty;
    o_ovf      = i_push & w_full & ~w_pop;
    // In overwrite mode a full push still writes; the head is advanced
    // past the oldest entry in the same cycle so the count stays at DEPTH.
    w_wr       = i_push & (~o_ovf | OVR_MODE);
    w_drop_old = o_ovf & OVR_MODE;
    o_head     = o_empty ? '0 : r_mem[r_rd];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)
        r_wr <= r_wr + 1'b1;
      if (w_pop | w_drop_old)
        r_rd <= r_rd + 1'b1;
      if (w_wr & ~w_pop & ~w_drop_old)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop & ~w_wr)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: o_head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/gptp_rx_mport.sv
`default_nettype none
// ============================================================================
// Module  : gptp_rx_mport
// Purpose : Multi-port gPTP receive path. Round-robin accepts one frame per
//           cycle from N_PORT inputs, decodes messageType and stores
//           {sequenceId, rx_ts, msg_ts} in per-port, per-type FIFOs that the
//           gPTP core reads in a single show-ahead handshake.
// Ports   : clk, reset (async active-low)
//           gptp_rv_data/vaild/ready : per-port frame input handshake
//           rx_gptp_rd_port/type/ready : buffer select and pop
//           rx_gptp_rd_vaild/seq/rx_ts/msg_ts : non-empty map and head data
//           ovf_cnt, drop_cnt : saturating event counters
// Revision: 1.0 - initial release
// ============================================================================
module gptp_rx_mport
  import gptp_pkg::*;
#(
  parameter int N_PORT   = 2,
  parameter int FRAME_W  = 432,
  parameter int TS_W     = 80,
  parameter int DEPTH    = 4,
  parameter int OVR_MODE = 0,
  parameter int PW       = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORT*FRAME_W-1:0] gptp_rv_data,
  input  logic [N_PORT-1:0]         gptp_rv_vaild,
  output logic [N_PORT-1:0]         gptp_rv_ready,
  input  logic [PW-1:0]             rx_gptp_rd_port,
  input  logic [2:0]                rx_gptp_rd_type,
  input  logic                      rx_gptp_rd_ready,
  output logic [7:0]                rx_gptp_rd_vaild,
  output logic [15:0]               rx_gptp_rd_seq,
  output logic [TS_W-1:0]           rx_gptp_rd_rx_ts,
  output logic [TS_W-1:0]           rx_gptp_rd_msg_ts,
  output logic [15:0]               ovf_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int c_NB = N_PORT * c_N_TYPE;

  logic [PW-1:0]       r_rr;
  logic [15:0]         r_ovf;
  logic [15:0]         r_drop;

  logic [N_PORT-1:0]   w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_acc;
  logic [FRAME_W-1:0]  w_frame;
  logic [3:0]          w_map;
  entry_t              w_entry;
  entry_t              w_sel;
  logic                w_rd_port_ok;
  logic                w_rd_type_ok;
  logic                w_ovf_any;
  logic                w_drop;
  logic                w_unused_frame;

  logic [c_NB-1:0]     w_empty;
  logic [c_NB-1:0]     w_ovf;
  logic [c_NB-1:0]     w_push;
  logic [c_NB-1:0]     w_pop;
  entry_t              w_head [c_NB];

  // Round-robin: first asserted vaild bit at or after r_rr, wrapping.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_acc     = 1'b0;
    for (int k = 0; k < N_PORT; k++) begin
      if (!w_acc && gptp_rv_vaild[(int'(r_rr) + k) % N_PORT]) begin
        w_acc     = 1'b1;
        w_gnt_idx = PW'((int'(r_rr) + k) % N_PORT);
      end
    end
    w_gnt[w_gnt_idx] = w_acc;
  end

  assign gptp_rv_ready = reset ? w_gnt : '0;

  assign w_frame = gptp_rv_data[int'(w_gnt_idx)*FRAME_W +: FRAME_W];
  assign w_map   = type_map(w_frame[c_MT_LSB +: 4]);
  assign w_entry = {w_frame[c_SEQ_LSB +: 16],
                    w_frame[c_RX_TS_LSB +: c_TS_W],
                    w_frame[c_MSG_TS_LSB +: c_TS_W]};
  assign w_unused_frame = ^w_frame[c_MSG_TS_LSB-1:0];

  assign w_rd_port_ok = (int'(rx_gptp_rd_port) < N_PORT);
  assign w_rd_type_ok = (rx_gptp_rd_type != 3'd7);

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    for (genvar t = 0; t < c_N_TYPE; t++) begin : g_type
      localparam int c_B = p*c_N_TYPE + t;

      assign w_push[c_B] = w_acc & w_map[3] & (w_gnt_idx == PW'(p)) &
                           (w_map[2:0] == 3'(t));
      assign w_pop[c_B]  = rx_gptp_rd_ready & w_rd_port_ok &
                           (rx_gptp_rd_port == PW'(p)) &
                           (rx_gptp_rd_type == 3'(t));

      gptp_rx_fifo #(
        .DEPTH    (DEPTH),
        .W        ($bits(entry_t)),
        .OVR_MODE (OVR_MODE != 0)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push[c_B]),
        .i_pop   (w_pop[c_B]),
        .i_data  (w_entry),
        .o_head  (w_head[c_B]),
        .o_empty (w_empty[c_B]),
        .o_ovf   (w_ovf[c_B])
      );
    end
  end

  always_comb begin
    rx_gptp_rd_vaild = '0;
    w_sel            = '0;
    if (w_rd_port_ok) begin
      for (int k = 0; k < c_N_TYPE; k++)
        rx_gptp_rd_vaild[k] = ~w_empty[int'(rx_gptp_rd_port)*c_N_TYPE + k];
      if (w_rd_type_ok)
        w_sel = w_head[int'(rx_gptp_rd_port)*c_N_TYPE + int'(rx_gptp_rd_type)];
    end
  end

  assign rx_gptp_rd_seq    = w_sel.seq;
  assign rx_gptp_rd_rx_ts  = w_sel.rx_ts[TS_W-1:0];
  assign rx_gptp_rd_msg_ts = w_sel.msg_ts[TS_W-1:0];

  // Only one frame is accepted per cycle, so at most one buffer overflows.
  assign w_ovf_any = |w_ovf;
  assign w_drop    = w_acc & ~w_map[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr   <= '0;
      r_ovf  <= '0;
      r_drop <= '0;
    end else begin
      if (w_acc)
        r_rr <= PW'((int'(w_gnt_idx) + 1) % N_PORT);
      if (w_ovf_any && (r_ovf != 16'hFFFF))
        r_ovf <= r_ovf + 16'd1;
      if (w_drop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  assign ovf_cnt  = r_ovf;
  assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_gptp_rx_mport.sv
`default_nettype none
// ============================================================================
// Module  : tb_gptp_rx_mport
// Purpose : Self-checking bench for gptp_rx_mport. Two instances share all
//           inputs: one drops the newest frame when full, one overwrites the
//           oldest. A queue-based reference model tracks both.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gptp_rx_mport;

  localparam int N  = 2;
  localparam int FW = 432;
  localparam int D  = 4;

  logic            clk;
  logic            reset;
  logic [N*FW-1:0] data;
  logic [N-1:0]    vld;
  logic [0:0]      rd_port;
  logic [2:0]      rd_type;
  logic            rd_ready;

  logic [N-1:0] rdy0, rdy1;
  logic [7:0]   vaild0, vaild1;
  logic [15:0]  seq0, seq1;
  logic [79:0]  rxts0, rxts1, msgts0, msgts1;
  logic [15:0]  ovf0, ovf1, drop0, drop1;

  gptp_rx_mport #(.N_PORT(N), .FRAME_W(FW), .TS_W(80), .DEPTH(D), .OVR_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .gptp_rv_data(data), .gptp_rv_vaild(vld),
    .gptp_rv_ready(rdy0), .rx_gptp_rd_port(rd_port), .rx_gptp_rd_type(rd_type),
    .rx_gptp_rd_ready(rd_ready), .rx_gptp_rd_vaild(vaild0), .rx_gptp_rd_seq(seq0),
    .rx_gptp_rd_rx_ts(rxts0), .rx_gptp_rd_msg_ts(msgts0), .ovf_cnt(ovf0), .drop_cnt(drop0));

  gptp_rx_mport #(.N_PORT(N), .FRAME_W(FW), .TS_W(80), .DEPTH(D), .OVR_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .gptp_rv_data(data), .gptp_rv_vaild(vld),
    .gptp_rv_ready(rdy1), .rx_gptp_rd_port(rd_port), .rx_gptp_rd_type(rd_type),
    .rx_gptp_rd_ready(rd_ready), .rx_gptp_rd_vaild(vaild1), .rx_gptp_rd_seq(seq1),
    .rx_gptp_rd_rx_ts(rxts1), .rx_gptp_rd_msg_ts(msgts1), .ovf_cnt(ovf1), .drop_cnt(drop1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue per (mode, port, type) at index mode*14+port*7+type
  logic [175:0] mq [28][$];
  int           m_rr;
  int           m_ovf [2];
  int           m_drop;
  int           last_g;

  function automatic int ref_idx(input logic [3:0] mt);
    case (mt)
      4'h0: return 0;
      4'h2: return 1;
      4'h3: return 2;
      4'h8: return 3;
      4'hA: return 4;
      4'hB: return 5;
      4'hC: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < N; k++)
      if (vld[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    g = exp_grant();
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  function automatic logic [7:0] exp_vaild(input int m);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 7; k++)
      if (mq[m*14 + int'(rd_port)*7 + k].size() > 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [175:0] exp_head(input int m);
    int i;
    if (rd_type == 3'd7) return '0;
    i = m*14 + int'(rd_port)*7 + int'(rd_type);
    if (mq[i].size() == 0) return '0;
    return mq[i][0];
  endfunction

  function automatic logic [79:0] rnd80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  function automatic logic [FW-1:0] mk(input logic [3:0] mt, input logic [15:0] sq,
                                       input logic [79:0] rx, input logic [79:0] ms);
    logic [FW-1:0] f;
    for (int i = 0; i < FW; i++) f[i] = 1'($urandom);
    f[431:352] = rx;
    f[351:348] = mt;
    f[347:332] = sq;
    f[331:252] = ms;
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 28; i++) mq[i].delete();
    m_rr = 0; m_ovf[0] = 0; m_ovf[1] = 0; m_drop = 0;
  endtask

  // Applies the coming clock edge to the model, then advances to posedge+1.
  task automatic step();
    int g, ti, pi, bi;
    logic [FW-1:0] fr;
    logic [175:0] e;
    bit popok [2];
    int pre [2];
    g = exp_grant();
    last_g = g;
    pi = int'(rd_port)*7 + int'(rd_type);
    for (int m = 0; m < 2; m++)
      popok[m] = rd_ready && (rd_type != 3'd7) && (mq[m*14 + pi].size() > 0);
    ti = -1;
    if (g >= 0) begin
      fr = data[g*FW +: FW];
      ti = ref_idx(fr[351:348]);
      m_rr = (g + 1) % N;
      if (ti < 0) m_drop++;
    end
    for (int m = 0; m < 2; m++)
      pre[m] = (ti >= 0) ? mq[m*14 + g*7 + ti].size() : 0;
    for (int m = 0; m < 2; m++)
      if (popok[m]) void'(mq[m*14 + pi].pop_front());
    if (g >= 0 && ti >= 0) begin
      e = {fr[347:332], fr[431:352], fr[331:252]};
      for (int m = 0; m < 2; m++) begin
        bi = m*14 + g*7 + ti;
        if (pre[m] == D && !(popok[m] && pi == g*7 + ti)) begin
          m_ovf[m]++;
          if (m == 1) begin
            void'(mq[bi].pop_front());
            mq[bi].push_back(e);
          end
        end else begin
          mq[bi].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld = '0; rd_ready = 1'b0; rd_port = '0; rd_type = '0; data = '0;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    vld = '0; rd_ready = 1'b0; rd_port = '0; rd_type = '0;
    data = {mk(4'h0, 16'h1, 80'h0, 80'h0), mk(4'h0, 16'h2, 80'h0, 80'h0)};
    reset = 1'b0;
    model_clear();
    #1;
    vld = 2'b11;
    #1;
    n_cmp++; if (rdy0 !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b exp 00", rdy0); end
    n_cmp++; if (vaild0 !== 8'h00 || vaild1 !== 8'h00) begin n_err++; $display("FAIL reset_vaild got %h/%h exp 00", vaild0, vaild1); end
    n_cmp++; if (ovf0 !== 16'd0 || drop0 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0", ovf0, drop0); end
    n_cmp++; if (seq0 !== 16'd0 || rxts0 !== 80'd0) begin n_err++; $display("FAIL reset_data got %h/%h exp 0", seq0, rxts0); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 2'b01 || rdy1 !== 2'b01) begin n_err++; $display("FAIL reset_first_grant got %b/%b exp 01", rdy0, rdy1); end
    vld = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_sync();
    do_reset();
    data[0 +: FW] = mk(4'h0, 16'h0010, 80'h1, 80'h2);
    vld = 2'b01;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 2'b01 || rdy1 !== 2'b01) begin n_err++; $display("FAIL sync_ready got %b/%b exp 01", rdy0, rdy1); end
    step();
    vld = '0;
    @(negedge clk);
    n_cmp++; if (vaild0 !== 8'h01 || vaild1 !== 8'h01) begin n_err++; $display("FAIL sync_vaild got %h/%h exp 01", vaild0, vaild1); end
    n_cmp++; if (seq0 !== 16'h0010 || rxts0 !== 80'h1 || msgts0 !== 80'h2)
      begin n_err++; $display("FAIL sync_head got %h/%h/%h exp 0010/1/2", seq0, rxts0, msgts0); end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (vaild0 !== 8'h00 || seq0 !== 16'h0) begin n_err++; $display("FAIL sync_pop got %h/%h exp 00/0", vaild0, seq0); end
  endtask

  task automatic test_rr();
    logic [15:0] ns [2];
    logic [N-1:0] er;
    do_reset();
    ns[0] = 16'd100; ns[1] = 16'd200;
    data[0 +: FW]  = mk(4'h3, ns[0], rnd80(), rnd80());
    data[FW +: FW] = mk(4'h3, ns[1], rnd80(), rnd80());
    vld = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      er = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (rdy0 !== er) begin n_err++; $display("FAIL rr_grant %0d got %b exp %b", i, rdy0, er); end
      step();
      ns[i % 2] = ns[i % 2] + 16'd1;
      data[(i % 2)*FW +: FW] = mk(4'h3, ns[i % 2], rnd80(), rnd80());
    end
    vld = '0;
    rd_type = 3'd2;
    for (int p = 0; p < 2; p++) begin
      rd_port = 1'(p);
      for (int e = 0; e < 2; e++) begin
        @(negedge clk);
        n_cmp++; if (seq0 !== 16'(100*(p+1) + e) || vaild0[2] !== 1'b1)
          begin n_err++; $display("FAIL rr_order p%0d e%0d got %0d exp %0d", p, e, seq0, 100*(p+1)+e); end
        n_cmp++; if ({seq1, rxts1, msgts1} !== exp_head(1))
          begin n_err++; $display("FAIL rr_head1 p%0d e%0d got %h exp %h", p, e, {seq1, rxts1, msgts1}, exp_head(1)); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (vaild0 !== 8'h00) begin n_err++; $display("FAIL rr_drained p%0d got %h exp 00", p, vaild0); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rd_port = 1'b1; rd_type = 3'd3;
    vld = 2'b10;
    for (int s = 1; s <= 5; s++) begin
      data[FW +: FW] = mk(4'h8, 16'(s), rnd80(), rnd80());
      step();
    end
    vld = '0;
    @(negedge clk);
    n_cmp++; if (ovf0 !== 16'd1 || ovf1 !== 16'd1) begin n_err++; $display("FAIL ovf_cnt got %0d/%0d exp 1/1", ovf0, ovf1); end
    n_cmp++; if (seq0 !== 16'd1) begin n_err++; $display("FAIL ovf_drop_head got %0d exp 1", seq0); end
    n_cmp++; if (seq1 !== 16'd2) begin n_err++; $display("FAIL ovf_over_head got %0d exp 2", seq1); end
    n_cmp++; if (vaild0 !== 8'h08 || vaild1 !== 8'h08) begin n_err++; $display("FAIL ovf_vaild got %h/%h exp 08", vaild0, vaild1); end
  endtask

  task automatic test_full_pushpop();
    int x0 [4];
    int x1 [4];
    x0 = '{2, 3, 4, 9};
    x1 = '{3, 4, 5, 9};
    data[FW +: FW] = mk(4'h8, 16'd9, rnd80(), rnd80());
    vld = 2'b10;
    rd_ready = 1'b1;
    step();
    vld = '0;
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (ovf0 !== 16'd1 || ovf1 !== 16'd1) begin n_err++; $display("FAIL fpp_ovf got %0d/%0d exp 1/1", ovf0, ovf1); end
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      n_cmp++; if (seq0 !== 16'(x0[e]) || seq1 !== 16'(x1[e]))
        begin n_err++; $display("FAIL fpp_order %0d got %0d/%0d exp %0d/%0d", e, seq0, seq1, x0[e], x1[e]); end
      n_cmp++; if ({seq0, rxts0, msgts0} !== exp_head(0))
        begin n_err++; $display("FAIL fpp_head0 %0d got %h exp %h", e, {seq0, rxts0, msgts0}, exp_head(0)); end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (vaild0 !== 8'h00 || vaild1 !== 8'h00) begin n_err++; $display("FAIL fpp_count got %h/%h exp 00", vaild0, vaild1); end
  endtask

  task automatic test_drop();
    do_reset();
    data[0 +: FW] = mk(4'h1, 16'h55, rnd80(), rnd80());
    vld = 2'b01;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 2'b01) begin n_err++; $display("FAIL drop_ready got %b exp 01", rdy0); end
    step();
    vld = '0;
    @(negedge clk);
    n_cmp++; if (drop0 !== 16'd1 || drop1 !== 16'd1) begin n_err++; $display("FAIL drop_cnt got %0d/%0d exp 1", drop0, drop1); end
    for (int p = 0; p < 2; p++) begin
      rd_port = 1'(p);
      #1;
      n_cmp++; if (vaild0 !== 8'h00) begin n_err++; $display("FAIL drop_vaild p%0d got %h exp 00", p, vaild0); end
    end
    rd_port = 1'b0; rd_type = 3'd0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (vaild0 !== 8'h00 || ovf0 !== 16'd0 || drop0 !== 16'd1)
      begin n_err++; $display("FAIL empty_pop got %h/%0d/%0d exp 00/0/1", vaild0, ovf0, drop0); end
    rd_type = 3'd7;
    #1;
    n_cmp++; if (seq0 !== 16'd0 || vaild0[7] !== 1'b0) begin n_err++; $display("FAIL type7 got %h/%b exp 0/0", seq0, vaild0[7]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vld = 2'b01;
    for (int s = 1; s <= 3; s++) begin
      data[0 +: FW] = mk(4'h0, 16'(s), rnd80(), rnd80());
      step();
    end
    data[FW +: FW] = mk(4'h1, 16'h77, rnd80(), rnd80());
    vld = 2'b10;
    step();
    data[0 +: FW]  = mk(4'h3, 16'h10, rnd80(), rnd80());
    data[FW +: FW] = mk(4'h3, 16'h20, rnd80(), rnd80());
    vld = 2'b11;
    rd_port = 1'b0; rd_type = 3'd0;
    @(negedge clk);
    n_cmp++; if (vaild0 !== 8'h01 || drop0 !== 16'd1 || rdy0 !== 2'b01)
      begin n_err++; $display("FAIL mid_pre got %h/%0d/%b exp 01/1/01", vaild0, drop0, rdy0); end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (vaild0 !== 8'h00 || vaild1 !== 8'h00 || seq0 !== 16'd0)
      begin n_err++; $display("FAIL mid_rst_data got %h/%h/%h exp 0", vaild0, vaild1, seq0); end
    n_cmp++; if (drop0 !== 16'd0 || rdy0 !== 2'b00) begin n_err++; $display("FAIL mid_rst_cnt got %0d/%b exp 0/00", drop0, rdy0); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 2'b01) begin n_err++; $display("FAIL mid_first_grant got %b exp 01", rdy0); end
    vld = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] mts [5];
    mts = '{4'h0, 4'h3, 4'h8, 4'h1, 4'hB};
    do_reset();
    last_g = -1;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!vld[p] || last_g == p) begin
          vld[p] = ($urandom_range(0, 3) != 0);
          data[p*FW +: FW] = mk(mts[$urandom_range(0, 4)], 16'($urandom), rnd80(), rnd80());
        end
      end
      rd_port  = 1'($urandom);
      rd_type  = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'(mts[$urandom_range(0, 2)] == 4'h0 ? 0 :
                                                       ($urandom_range(0, 1) ? 2 : 3));
      rd_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n_cmp++; if (rdy0 !== exp_rdy() || rdy1 !== exp_rdy())
        begin n_err++; $display("FAIL rnd_ready c%0d got %b/%b exp %b", c, rdy0, rdy1, exp_rdy()); end
      n_cmp++; if (vaild0 !== exp_vaild(0) || vaild1 !== exp_vaild(1))
        begin n_err++; $display("FAIL rnd_vaild c%0d got %h/%h exp %h/%h", c, vaild0, vaild1, exp_vaild(0), exp_vaild(1)); end
      n_cmp++; if ({seq0, rxts0, msgts0} !== exp_head(0))
        begin n_err++; $display("FAIL rnd_head0 c%0d got %h exp %h", c, {seq0, rxts0, msgts0}, exp_head(0)); end
      n_cmp++; if ({seq1, rxts1, msgts1} !== exp_head(1))
        begin n_err++; $display("FAIL rnd_head1 c%0d got %h exp %h", c, {seq1, rxts1, msgts1}, exp_head(1)); end
      n_cmp++; if (ovf0 !== 16'(m_ovf[0]) || ovf1 !== 16'(m_ovf[1]) || drop0 !== 16'(m_drop) || drop1 !== 16'(m_drop))
        begin n_err++; $display("FAIL rnd_cnt c%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d", c, ovf0, ovf1, drop0, drop1, m_ovf[0], m_ovf[1], m_drop); end
      step();
    end
    vld = '0;
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; vld = '0; data = '0; rd_port = '0; rd_type = '0; rd_ready = 1'b0;
    last_g = -1;
    model_clear();
    test_reset();
    test_sync();
    test_rr();
    test_overflow();
    test_full_pushpop();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gptp_rx_mport.md
Name: gptp_rx_mport

Overview:
Multi-port successor to the gPTP receive path. It arbitrates frames from N_PORT receive FIFOs, decodes the gPTP messageType, and stores {sequenceId, rx timestamp, carried timestamp} into per-port, per-message-type buffers of depth DEPTH. The gPTP core reads each entry in one handshake: Pdelay_Resp no longer needs two reads. Overflow policy is selectable, and overflow/drop events are counted.

Parameters:
N_PORT, 2, number of receive ports (1..8)
FRAME_W, 432, width of one parsed frame word per port
TS_W, 80, timestamp width (48b seconds + 32b ns)
DEPTH, 4, entries per (port,type) buffer; power of two, >=2
OVR_MODE, 0, 0 = drop newest when full; 1 = overwrite oldest

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
gptp_rv_data  in  N_PORT*FRAME_W  frame word of port i at [i*FRAME_W +: FRAME_W]; held stable while valid
gptp_rv_vaild  in  N_PORT  frame present per port
gptp_rv_ready  out  N_PORT  one-hot accept; frame consumed when vaild&ready
rx_gptp_rd_port  in  PW=max(1,$clog2(N_PORT))  port selected for reading
rx_gptp_rd_type  in  3  type index selected for reading
rx_gptp_rd_ready  in  1  pop head of selected buffer
rx_gptp_rd_vaild  out  8  bit k = buffer (rd_port,k) non-empty
rx_gptp_rd_seq  out  16  head sequenceId of selected buffer
rx_gptp_rd_rx_ts  out  TS_W  head ingress timestamp
rx_gptp_rd_msg_ts  out  TS_W  head carried timestamp
ovf_cnt  out  16  saturating count of full-buffer events
drop_cnt  out  16  saturating count of unsupported-type frames

Behaviour:
- Frame fields (fixed): [431:352] rx_ts, [351:348] messageType, [347:332] sequenceId, [331:252] msg_ts; remaining bits ignored.
- Type index map: Sync 0x0->0, Pdelay_Req 0x2->1, Pdelay_Resp 0x3->2, Follow_Up 0x8->3, Pdelay_Resp_Follow_Up 0xA->4, Announce 0xB->5, Signaling 0xC->6. Any other value is unsupported. Index 7 is never written, so rd_vaild[7] is always 0.
- Arbitration: round-robin grant among asserted gptp_rv_vaild bits, starting at rr_ptr. gptp_rv_ready = grant, combinational. At most one frame is accepted per cycle. On accept, rr_ptr <= granted+1 mod N_PORT; otherwise rr_ptr holds.
- Accept is unconditional: a full buffer never stalls the port.
- Write: on accept at cycle t, the entry is written at the t clock edge. The rd_vaild bit and head data reflect it from t+1.
- Unsupported type: the frame is consumed, nothing is stored, drop_cnt++.
- Full buffer, no simultaneous pop:
  - OVR_MODE=0: frame discarded, ovf_cnt++.
  - OVR_MODE=1: oldest entry discarded, new entry written at tail, ovf_cnt++.
- Full buffer with a same-cycle pop of that buffer: push and pop both occur, no overflow, count unchanged.
- Read: show-ahead. rd_seq/rd_rx_ts/rd_msg_ts combinationally present the head of buffer (rd_port, rd_type); they are all-zero when that buffer is empty. rd_ready pops only if the buffer is non-empty; rd_ready on an empty buffer is ignored.
- rd_port >= N_PORT: rd_vaild = 0, data = 0, pop ignored.
- Empty buffer with simultaneous push and pop: the pop is ignored and the push is stored.
- Counters saturate at 16'hFFFF.
- Reset (async, any time including mid-frame): all pointers and counts go to 0, rr_ptr = 0, counters = 0, every buffer empty. Outputs: rd_vaild = 0, data = 0, gptp_rv_ready follows vaild with rr_ptr = 0 once reset deasserts. gptp_rv_ready = 0 while reset is asserted.

Decomposition:
- gptp_pkg: messageType constants, type-index map function, field offset localparams, entry struct {seq[15:0], rx_ts, msg_ts}.
- Sub-module gptp_rx_fifo: one DEPTH-entry show-ahead FIFO with push/pop/full/empty and overwrite-oldest support. Instantiate N_PORT*7 copies via generate.
- The top holds the round-robin arbiter, decode, read mux and counters.

Test Plan:
1. Port0 sends Sync seq=0x0010 rx_ts=80'h1, msg_ts=80'h2 -> ready[0] same cycle. Next cycle rd_port=0 gives rd_vaild=8'h01, head {0x0010,1,2}. rd_ready -> rd_vaild=0.
2. Both ports valid for 4 cycles with Pdelay_Resp -> grants alternate 0,1,0,1. Each port buffer index 2 holds 2 entries in order.
3. OVR_MODE=0, DEPTH=4, 5 Follow_Up seq 1..5 on port1 -> head seq=1, 4 entries, ovf_cnt=1. OVR_MODE=1 -> head seq=2, ovf_cnt=1.
4. Buffer full plus simultaneous push seq=9 and pop -> ovf_cnt unchanged, tail=9, count stays 4.
5. messageType 0x1 frame -> consumed, drop_cnt=1, all rd_vaild 0. rd_ready on empty buffer -> no state change.
6. Assert reset with 3 stored entries and a frame pending -> rd_vaild=0 and counters=0 immediately. After release, port0 is granted first.
